argmax_tile_sched: RTL and testbench

Sequencer and reducer for the Argmax stage that follows the HBM MVM + BN + residual path. It consumes the MVM output stream one Tout-lane beat at a time, in tile-major, token-minor order, and keeps a running FP16 maximum and its channel index per token across all CHout/Tout tiles. After each token's final tile it emits one result per token over a valid/ready handshake, and reports completion to the command layer.

---
 rtl/argmax_tile_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_argmax_tile_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_tile_sched.sv
// Argmax sequencer/reducer: running FP16 max and channel index per token across all tiles.
// Optional ARGMAX_PAD_MASK_EN: lanes with channel index >= cfg_ch_out never win.
module argmax_tile_sched #(
  parameter int TOUT      = 32,
  parameter int DAT_DW    = 16,
  parameter int IDX_DW    = 16,
  parameter int MAX_TOKEN = 32,
  parameter int TOK_DW    = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [TOK_DW-1:0]      cfg_tokens,
  input  logic [IDX_DW-1:0]      cfg_tiles,
  input  logic [IDX_DW-1:0]      cfg_ch_out,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOUT*DAT_DW-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOK_DW-1:0]      out_token,
  output logic [IDX_DW-1:0]      out_index,
  output logic [DAT_DW-1:0]      out_value
);

  localparam int LANE_W = $clog2(TOUT);
  localparam int TAB_AW = $clog2(MAX_TOKEN);
  localparam int TAB_N  = 2 ** TAB_AW;
  localparam int KEY_W  = DAT_DW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Maps FP16 onto an unsigned total order: negatives reversed below positives.
  function automatic logic [DAT_DW-1:0] ord_key(input logic [DAT_DW-1:0] x);
    return x[DAT_DW-1] ? ~x : {1'b1, x[DAT_DW-2:0]};
  endfunction

  state_t              state;
  logic [TOK_DW-1:0]   tokens_r;
  logic [IDX_DW-1:0]   tiles_r;
  logic [TOK_DW-1:0]   tok;
  logic [IDX_DW-1:0]   tile;
`ifdef ARGMAX_PAD_MASK_EN
  logic [IDX_DW-1:0]   ch_out_r;
`else
  logic                unused_cfg;
  assign unused_cfg = ^cfg_ch_out;
`endif

  logic                   vld_p0, first_p0, last_p0;
  logic [TOK_DW-1:0]      tok_p0;
  logic [IDX_DW-1:0]      base_p0;
  logic [TOUT*DAT_DW-1:0] data_p0;

  logic                   vld_p1, first_p1, last_p1, bany_p1;
  logic [TOK_DW-1:0]      tok_p1;
  logic [IDX_DW-1:0]      bidx_p1;
  logic [DAT_DW-1:0]      bval_p1;
  logic [DAT_DW-1:0]      old_val_p1;
  logic [IDX_DW-1:0]      old_idx_p1;
  logic                   old_has_p1;

  logic [DAT_DW-1:0] tab_val [TAB_N];
  logic [IDX_DW-1:0] tab_idx [TAB_N];
  logic              tab_has [TAB_N];

  logic [KEY_W-1:0]  tk [1:2*TOUT-1];
  logic [LANE_W-1:0] tl [1:2*TOUT-1];
  logic [TOUT-1:0]   lane_ok;
  logic [LANE_W-1:0] win_lane;
  logic              win_any;

  logic              take_new, m_has;
  logic [DAT_DW-1:0] m_val;
  logic [IDX_DW-1:0] m_idx;
  logic              stall, accept, tab_wr;

  // A last-tile beat cannot move while the output register is occupied and blocked.
  assign stall    = out_valid && !out_ready && ((vld_p0 && last_p0) || (vld_p1 && last_p1));
  assign in_ready = (state == S_RUN) && !stall;
  assign accept   = in_valid && in_ready;
  assign tab_wr   = vld_p1 && !last_p1 && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      tok      <= '0;
      tile     <= '0;
      tokens_r <= '0;
      tiles_r  <= '0;
`ifdef ARGMAX_PAD_MASK_EN
      ch_out_r <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          tokens_r <= cfg_tokens;
          tiles_r  <= cfg_tiles;
`ifdef ARGMAX_PAD_MASK_EN
          ch_out_r <= cfg_ch_out;
`endif
          tok  <= '0;
          tile <= '0;
          if (cfg_tokens == '0 || cfg_tiles == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: if (accept) begin
          if (tok == tokens_r - 1'b1) begin
            tok  <= '0;
            tile <= tile + 1'b1;
            if (tile == tiles_r - 1'b1) state <= S_DRAIN;
          end else begin
            tok <= tok + 1'b1;
          end
        end
        S_DRAIN: if (!vld_p0 && !vld_p1 && out_valid && out_ready) begin
          state <= S_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_token <= '0;
      out_index <= '0;
      out_value <= '0;
    end else begin
      if (!stall) begin
        vld_p0 <= accept;
        vld_p1 <= vld_p0;
      end
      if (vld_p1 && last_p1 && !stall) begin
        out_valid <= 1'b1;
        out_token <= tok_p1;
        out_index <= m_idx;
        out_value <= m_val;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Stage p0 -> p1: lane reduction tree; the right child wins only when strictly greater.
  always_comb begin
    for (int l = 0; l < TOUT; l++) begin
`ifdef ARGMAX_PAD_MASK_EN
      lane_ok[l] = (base_p0 + IDX_DW'(l)) < ch_out_r;
`else
      lane_ok[l] = 1'b1;
`endif
      tk[TOUT+l] = {lane_ok[l], ord_key(data_p0[l*DAT_DW +: DAT_DW])};
      tl[TOUT+l] = LANE_W'(l);
    end
    for (int i = TOUT - 1; i >= 1; i--) begin
      if (tk[2*i+1] > tk[2*i]) begin
        tk[i] = tk[2*i+1];
        tl[i] = tl[2*i+1];
      end else begin
        tk[i] = tk[2*i];
        tl[i] = tl[2*i];
      end
    end
    win_lane = tl[1];
    win_any  = tk[1][KEY_W-1];
  end

  // Stage p1 -> out/table: merge with the token's running best.
  always_comb begin
    take_new = first_p1 || !old_has_p1 ||
               (bany_p1 && (ord_key(bval_p1) > ord_key(old_val_p1)));
    m_val = take_new ? bval_p1 : old_val_p1;
    m_idx = take_new ? bidx_p1 : old_idx_p1;
    m_has = take_new ? bany_p1 : old_has_p1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_p0  <= in_data;
      tok_p0   <= tok;
      first_p0 <= (tile == '0);
      last_p0  <= (tile == tiles_r - 1'b1);
      base_p0  <= tile << LANE_W;
    end
    if (!stall) begin
      tok_p1   <= tok_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      bval_p1  <= data_p0[win_lane*DAT_DW +: DAT_DW];
      bidx_p1  <= base_p0 | IDX_DW'(win_lane);
      bany_p1  <= win_any;
      if (tab_wr && tok_p1 == tok_p0) begin
        old_val_p1 <= m_val;
        old_idx_p1 <= m_idx;
        old_has_p1 <= m_has;
      end else begin
        old_val_p1 <= tab_val[tok_p0[TAB_AW-1:0]];
        old_idx_p1 <= tab_idx[tok_p0[TAB_AW-1:0]];
        old_has_p1 <= tab_has[tok_p0[TAB_AW-1:0]];
      end
    end
    if (tab_wr) begin
      tab_val[tok_p1[TAB_AW-1:0]] <= m_val;
      tab_idx[tok_p1[TAB_AW-1:0]] <= m_idx;
      tab_has[tok_p1[TAB_AW-1:0]] <= m_has;
    end
  end

endmodule

// File: tb/tb_argmax_tile_sched.sv
// Scoreboard bench for argmax_tile_sched (TOUT=4); expectations from directed constants or a flat argmax model.
`timescale 1ns/1ps
module tb_argmax_tile_sched;
  localparam int TOUT = 4, DAT_DW = 16, IDX_DW = 16, MAX_TOKEN = 8, TOK_DW = 4;
`ifdef ARGMAX_PAD_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [TOK_DW-1:0] cfg_tokens = '0;
  logic [IDX_DW-1:0] cfg_tiles = '0, cfg_ch_out = '0;
  logic busy, done, in_ready, out_valid;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [TOUT*DAT_DW-1:0] in_data = '0;
  logic [TOK_DW-1:0] out_token;
  logic [IDX_DW-1:0] out_index;
  logic [DAT_DW-1:0] out_value;

  argmax_tile_sched #(.TOUT(TOUT), .DAT_DW(DAT_DW), .IDX_DW(IDX_DW),
                      .MAX_TOKEN(MAX_TOKEN), .TOK_DW(TOK_DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_tokens(cfg_tokens),
    .cfg_tiles(cfg_tiles), .cfg_ch_out(cfg_ch_out), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_token(out_token),
    .out_index(out_index), .out_value(out_value));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TOK_DW-1:0] tok;
    logic [IDX_DW-1:0] idx;
    logic [DAT_DW-1:0] val;
  } res_t;

  res_t sb[$];
  res_t exp_r, held_r;
  int   checks = 0, errors = 0;
  int   cyc = 0, hs_cyc = 0, rise_cyc = 0, acc_cyc = 0;
  bit   rdy_rand = 1'b0, hold_arm = 1'b0, held = 1'b0, prev_ov = 1'b0;
  int   hold_left = 0;
  logic [TOUT*DAT_DW-1:0] bt [0:63];

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (hold_arm) begin
      out_ready = 1'b0;
      if (out_valid) begin
        hold_arm  = 1'b0;
        hold_left = 10;
      end
    end else if (hold_left > 0) begin
      out_ready = 1'b0;
      hold_left = hold_left - 1;
    end else begin
      out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Output monitor: pops one expectation per handshake, checks payload stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      held    = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) rise_cyc = cyc;
      if (held) begin
        checks++;
        if (!out_valid || {out_token, out_index, out_value} != held_r) begin
          errors++;
          $display("FAIL stable_payload: got v=%0b %0h/%0h/%0h required v=1 %0h/%0h/%0h",
                   out_valid, out_token, out_index, out_value, held_r.tok, held_r.idx, held_r.val);
        end
      end
      if (hold_left > 0 && out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_backpressure: got %0b required 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got tok=%0d idx=%0d val=%h required no result",
                   out_token, out_index, out_value);
        end else begin
          exp_r = sb.pop_front();
          if ({out_token, out_index, out_value} != exp_r) begin
            errors++;
            $display("FAIL result: got tok=%0d idx=%0d val=%h required tok=%0d idx=%0d val=%h",
                     out_token, out_index, out_value, exp_r.tok, exp_r.idx, exp_r.val);
          end
        end
      end
      held    = out_valid && !out_ready;
      held_r  = {out_token, out_index, out_value};
      prev_ov = out_valid;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_token"}, 32'(out_token), 0);
    check({tag, "_out_index"}, 32'(out_index), 0);
    check({tag, "_out_value"}, 32'(out_value), 0);
  endtask

  function automatic logic [15:0] key16(input logic [15:0] x);
    return x[15] ? ~x : (x ^ 16'h8000);
  endfunction

  task automatic push_exp(input int t, input int idx, input logic [15:0] v);
    res_t r;
    r.tok = TOK_DW'(t);
    r.idx = IDX_DW'(idx);
    r.val = v;
    sb.push_back(r);
  endtask

  // Reference: flat argmax over every channel of the token; first (lowest) index wins ties.
  task automatic push_model(input int ntok, input int ntile, input int ch);
    for (int t = 0; t < ntok; t++) begin
      int best = -1, bi = 0;
      logic [15:0] bv = '0, v;
      for (int c = 0; c < ntile * TOUT; c++) begin
        v = bt[(c / TOUT) * ntok + t][(c % TOUT) * DAT_DW +: DAT_DW];
        if (MASK && c >= ch) continue;
        if (int'(key16(v)) > best) begin
          best = int'(key16(v));
          bi   = c;
          bv   = v;
        end
      end
      push_exp(t, bi, bv);
    end
  endtask

  task automatic fill_all(input int n, input logic [15:0] v);
    for (int b = 0; b < n; b++) bt[b] = {TOUT{v}};
  endtask

  task automatic set_lane(input int b, input int lane, input logic [15:0] v);
    bt[b][lane*DAT_DW +: DAT_DW] = v;
  endtask

  task automatic fill_rand(input int n);
    logic [15:0] v;
    for (int b = 0; b < n; b++)
      for (int l = 0; l < TOUT; l++) begin
        case ($urandom_range(0, 7))
          0: v = 16'h3C00;
          1: v = 16'hBC00;
          2: v = 16'h0000;
          3: v = 16'h8000;
          4: v = 16'h7BFF;
          5: v = 16'hFBFF;
          default: v = 16'($urandom);
        endcase
        set_lane(b, l, v);
      end
  endtask

  task automatic run_job(input int ntok, input int ntile, input int ch,
                         input bit vrand, input bit use_model);
    int n, b, guard;
    bit got;
    n = ntok * ntile;
    if (use_model) push_model(ntok, ntile, ch);
    cfg_tokens = TOK_DW'(ntok);
    cfg_tiles  = IDX_DW'(ntile);
    cfg_ch_out = IDX_DW'(ch);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b = 0;
    guard = 0;
    while (b < n && guard < 4000) begin
      in_data  = bt[b];
      in_valid = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (b == n - 1) acc_cyc = cyc;
        b++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    check("beats_accepted", 32'(b), 32'(n));
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", 32'(got), 1);
    if (got) begin
      check("done_after_handshake", 32'(cyc), 32'(hs_cyc + 1));
      check("busy_with_done", 32'(busy), 0);
    end
    check("results_pending", 32'(sb.size()), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic zero_job(input int ntok, input int ntile);
    cfg_tokens = TOK_DW'(ntok);
    cfg_tiles  = IDX_DW'(ntile);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    check("zero_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    check("zero_done_pulse", 32'(done), 0);
    @(posedge clk); #1;
  endtask

  task automatic load_t1();
    fill_all(2, 16'h0000);
    set_lane(0, 0, 16'h3C00); set_lane(0, 1, 16'h4000);
    set_lane(0, 2, 16'h0000); set_lane(0, 3, 16'hBC00);
    set_lane(1, 0, 16'h4200); set_lane(1, 1, 16'h3C00);
  endtask

  task automatic load_t3();
    fill_all(6, 16'hBC00);
    set_lane(5, 1, 16'hB800);
    set_lane(0, 3, 16'hBA00);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_t1();
    push_exp(0, 4, 16'h4200);
    run_job(1, 2, 8, 1'b0, 1'b0);
    check("t1_out_latency", 32'(rise_cyc), 32'(acc_cyc + 3));

    fill_all(3, 16'h3C00);
    push_exp(0, 0, 16'h3C00);
    run_job(1, 3, 12, 1'b1, 1'b0);

    fill_all(3, 16'h3C00);
    set_lane(0, 2, 16'h4000);
    set_lane(2, 2, 16'h4000);
    push_exp(0, 2, 16'h4000);
    run_job(1, 3, 12, 1'b0, 1'b0);

    load_t3();
    push_exp(0, 3, 16'hBA00);
    push_exp(1, 9, 16'hB800);
    run_job(2, 3, 12, 1'b1, 1'b0);

    load_t3();
    push_exp(0, 3, 16'hBA00);
    push_exp(1, 9, 16'hB800);
    hold_arm = 1'b1;
    run_job(2, 3, 12, 1'b0, 1'b0);

    fill_rand(8);
    hold_arm = 1'b1;
    run_job(4, 2, 8, 1'b0, 1'b1);

    fill_all(2, 16'hBC00);
    set_lane(1, 2, 16'h7BFF);
    set_lane(1, 3, 16'h7BFF);
    if (MASK) push_exp(0, 0, 16'hBC00);
    else      push_exp(0, 6, 16'h7BFF);
    run_job(1, 2, 6, 1'b0, 1'b0);

    zero_job(0, 3);
    zero_job(2, 0);

    fill_rand(5);
    run_job(1, 5, 20, 1'b0, 1'b1);

    rdy_rand = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int nt, nl;
      nt = $urandom_range(1, MAX_TOKEN);
      nl = $urandom_range(1, 6);
      fill_rand(nt * nl);
      run_job(nt, nl, $urandom_range(1, nl * TOUT), 1'b1, 1'b1);
    end
    rdy_rand = 1'b0;

    load_t1();
    cfg_tokens = TOK_DW'(1);
    cfg_tiles  = IDX_DW'(2);
    cfg_ch_out = IDX_DW'(8);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_data  = bt[0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = bt[1];
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(0, 4, 16'h4200);
    run_job(1, 2, 8, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
